// File: rtl/jtag_debug_port_if.sv
// rtl/jtag_debug_port_if.sv - UJTAG wrapper strobe bundle between TAP wrapper and debug responder
//
// Signals:
//   uireg   current user instruction (static during DR scans)
//   urstb   TAP reset, active low
//   udrck   data-register clock (TCK)
//   udrcap  Capture-DR state
//   udrsh   Shift-DR state
//   udrupd  Update-DR state
//   utdi    serial data from the host
//   utdo    serial data to the host
// Modports: master = TAP wrapper side, slave = responder side.

interface jtag_debug_port_if;
  logic [7:0] uireg;
  logic       urstb;
  logic       udrck;
  logic       udrcap;
  logic       udrsh;
  logic       udrupd;
  logic       utdi;
  logic       utdo;

  modport master (
    output uireg, urstb, udrck, udrcap, udrsh, udrupd, utdi,
    input  utdo
  );

  modport slave (
    input  uireg, urstb, udrck, udrcap, udrsh, udrupd, utdi,
    output utdo
  );
endinterface

// File: rtl/jtag_debug_port.sv
// rtl/jtag_debug_port.sv - UJTAG user data register responder for probe capture and control write
//
// Ports:
//   clk, reset_n  system clock (>= 8x TCK), asynchronous active-low reset
//   ujtag         UJTAG strobes in, utdo out (slave modport of jtag_debug_port_if)
//   probe         PROBE_W-bit debug vector, asynchronous to TCK
//   trig          snapshot trigger, present only with JTAG_DBG_TRIGGER_EN
//   ctrl_reg      8-bit control register loaded from the host
//   ctrl_update   one-clk pulse whenever ctrl_reg is written
// Build option: define JTAG_DBG_TRIGGER_EN for the armed probe snapshot.

module jtag_debug_port #(
  parameter int         PROBE_W  = 32,
  parameter logic [7:0] IR_PROBE = 8'h55,
  parameter logic [7:0] IR_CTRL  = 8'h56
) (
  input  logic               clk,
  input  logic               reset_n,
  jtag_debug_port_if.slave   ujtag,
  input  logic [PROBE_W-1:0] probe,
`ifdef JTAG_DBG_TRIGGER_EN
  input  logic               trig,
`endif
  output logic [7:0]         ctrl_reg,
  output logic               ctrl_update
);

  // Synchronizer bit order: {urstb, utdi, udrupd, udrsh, udrcap, udrck}
  logic [5:0]         raw;
  logic [5:0]         sync1;
  logic [5:0]         sync2;
  logic               ck_d;
  logic               upd_d;
  logic               ck_s, cap_s, sh_s, upd_s, tdi_s, rstb_s;
  logic               ck_rise, ck_fall, upd_rise, ir_sel;
  logic [7:0]         ir_q;
  logic [PROBE_W-1:0] sr;
  logic [PROBE_W-1:0] probe_src;
  logic [PROBE_W-1:0] ctrl_cap;
  logic [7:0]         ctrl_view;
  logic               utdo_q;

  assign raw = {ujtag.urstb, ujtag.utdi, ujtag.udrupd,
                ujtag.udrsh, ujtag.udrcap, ujtag.udrck};
  assign {rstb_s, tdi_s, upd_s, sh_s, cap_s, ck_s} = sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      ck_d  <= 1'b0;
      upd_d <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      ck_d  <= ck_s;
      upd_d <= upd_s;
    end
  end

  assign ck_rise  = ck_s & ~ck_d;
  assign ck_fall  = ~ck_s & ck_d;
  assign upd_rise = upd_s & ~upd_d;
  // uireg is stable during a scan, so it is used raw at detected TCK edges
  assign ir_sel   = (ujtag.uireg == IR_PROBE) || (ujtag.uireg == IR_CTRL);

`ifdef JTAG_DBG_TRIGGER_EN
  logic [2:0]         trig_sync;
  logic               trig_rise;
  logic               armed;
  logic               triggered;
  logic [PROBE_W-1:0] snap;

  assign trig_rise = trig_sync[1] & ~trig_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync <= '0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      snap      <= '0;
    end else begin
      trig_sync <= {trig_sync[1:0], trig};
      if (!rstb_s) begin
        armed     <= 1'b0;
        triggered <= 1'b0;
      end else if (upd_rise && ir_q == IR_CTRL) begin
        // ctrl_reg[0] is the arm bit; clearing it also drops the snapshot
        armed <= sr[0];
        if (!sr[0]) triggered <= 1'b0;
      end else if (trig_rise && armed && !triggered) begin
        snap      <= probe;
        triggered <= 1'b1;
      end
    end
  end

  assign probe_src = triggered ? snap : probe;
  assign ctrl_view = {triggered, ctrl_reg[6:0]};
`else
  assign probe_src = probe;
  assign ctrl_view = ctrl_reg;
`endif

  always_comb begin
    ctrl_cap      = '0;
    ctrl_cap[7:0] = ctrl_view;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr          <= '0;
      utdo_q      <= 1'b0;
      ctrl_reg    <= '0;
      ctrl_update <= 1'b0;
      ir_q        <= '0;
    end else if (!rstb_s) begin
      // TAP reset holds the scan path and control register clear
      sr          <= '0;
      utdo_q      <= 1'b0;
      ctrl_reg    <= '0;
      ctrl_update <= 1'b0;
    end else begin
      ctrl_update <= 1'b0;
      if (ck_rise || ck_fall) ir_q <= ujtag.uireg;
      if (ck_rise) begin
        if (cap_s) begin
          if (ujtag.uireg == IR_PROBE)     sr <= probe_src;
          else if (ujtag.uireg == IR_CTRL) sr <= ctrl_cap;
        end else if (sh_s && ir_sel) begin
          sr <= {tdi_s, sr[PROBE_W-1:1]};
        end
      end
      if (ck_fall) utdo_q <= ir_sel ? sr[0] : 1'b0;
      if (upd_rise && ir_q == IR_CTRL) begin
        ctrl_reg    <= sr[7:0];
        ctrl_update <= 1'b1;
      end
    end
  end

  assign ujtag.utdo = utdo_q;

endmodule

// File: tb/tb_jtag_debug_port.sv
// tb/tb_jtag_debug_port.sv - self-checking bench for jtag_debug_port

module tb_jtag_debug_port;
  localparam int         W    = 32;
  localparam logic [7:0] IR_P = 8'h55;
  localparam logic [7:0] IR_C = 8'h56;
`ifdef JTAG_DBG_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] probe;
  logic         trig;
  logic [7:0]   ctrl_reg;
  logic         ctrl_update;

  jtag_debug_port_if ujtag ();

  jtag_debug_port #(.PROBE_W(W), .IR_PROBE(IR_P), .IR_CTRL(IR_C)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ujtag       (ujtag),
    .probe       (probe),
`ifdef JTAG_DBG_TRIGGER_EN
    .trig        (trig),
`endif
    .ctrl_reg    (ctrl_reg),
    .ctrl_update (ctrl_update)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the data register as a bit queue (front = bit shifted out next);
  // every strobe takes effect three clk edges after it is driven.
  bit           mq[$];
  logic         m_tdo, m_upd, m_sel;
  logic [7:0]   m_ctrl, m_c8;
  logic [W-1:0] m_w, m_snap;
  bit           m_armed, m_trigd;
  logic [3:0]   h_ck, h_cap, h_sh, h_upd, h_tdi, h_rstb, h_trig;

  task automatic mq_load(input logic [W-1:0] w);
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(w[i]);
  endtask

  function automatic logic [W-1:0] mq_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = mq[i];
    return w;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      h_ck = '0; h_cap = '0; h_sh = '0; h_upd = '0; h_tdi = '0; h_rstb = '0; h_trig = '0;
      mq_load('0);
      m_tdo = 1'b0; m_upd = 1'b0; m_ctrl = '0; m_armed = 1'b0; m_trigd = 1'b0; m_snap = '0;
    end else begin
      h_ck   = {h_ck[2:0],   ujtag.udrck};
      h_cap  = {h_cap[2:0],  ujtag.udrcap};
      h_sh   = {h_sh[2:0],   ujtag.udrsh};
      h_upd  = {h_upd[2:0],  ujtag.udrupd};
      h_tdi  = {h_tdi[2:0],  ujtag.utdi};
      h_rstb = {h_rstb[2:0], ujtag.urstb};
      h_trig = {h_trig[2:0], trig};
      m_upd  = 1'b0;
      m_sel  = (ujtag.uireg == IR_P) || (ujtag.uireg == IR_C);
      if (!h_rstb[2]) begin
        mq_load('0);
        m_tdo = 1'b0; m_ctrl = '0; m_armed = 1'b0; m_trigd = 1'b0;
      end else begin
        if (h_ck[2] && !h_ck[3]) begin
          if (h_cap[2]) begin
            if (ujtag.uireg == IR_P) mq_load(m_trigd ? m_snap : probe);
            else if (ujtag.uireg == IR_C) begin
              m_c8 = m_ctrl;
              if (TRIG_EN) m_c8[7] = m_trigd;
              mq_load({{(W-8){1'b0}}, m_c8});
            end
          end else if (h_sh[2] && m_sel) begin
            void'(mq.pop_front());
            mq.push_back(h_tdi[2]);
          end
        end
        if (!h_ck[2] && h_ck[3]) m_tdo = m_sel ? mq[0] : 1'b0;
        if (h_upd[2] && !h_upd[3] && ujtag.uireg == IR_C) begin
          m_w    = mq_word();
          m_ctrl = m_w[7:0];
          m_upd  = 1'b1;
          if (TRIG_EN) begin
            m_armed = m_w[0];
            if (!m_w[0]) m_trigd = 1'b0;
          end
        end else if (TRIG_EN && h_trig[2] && !h_trig[3] && m_armed && !m_trigd) begin
          m_snap  = probe;
          m_trigd = 1'b1;
        end
      end
      if (chk_en) begin
        check("cyc_utdo", ujtag.utdo, m_tdo);
        check("cyc_ctrl_reg", ctrl_reg, m_ctrl);
        check("cyc_ctrl_update", ctrl_update, m_upd);
      end
    end
  end

  // One TCK period (4 clk low, 4 clk high); utdo is sampled just before the rise.
  task automatic tck(input logic cap, input logic sh, input logic tdi, output logic tdo);
    @(negedge clk);
    ujtag.udrck = 1'b0; ujtag.udrcap = cap; ujtag.udrsh = sh; ujtag.utdi = tdi;
    repeat (4) @(negedge clk);
    tdo = ujtag.utdo;
    ujtag.udrck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] ir, input int n, input logic [63:0] tdi,
                      output logic [63:0] rd);
    logic b;
    @(negedge clk);
    ujtag.uireg = ir;
    tck(1'b1, 1'b0, 1'b0, b);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      tck(1'b0, 1'b1, tdi[i], b);
      rd[i] = b;
    end
  endtask

  task automatic do_update(output int cnt, output int first);
    @(negedge clk);
    ujtag.udrsh = 1'b0; ujtag.udrupd = 1'b1;
    cnt = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ctrl_update) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    ujtag.udrupd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        b;
    logic [3:0]  acc;
    int          cnt, first;

    reset_n = 1'b0; probe = '0; trig = 1'b0;
    ujtag.uireg = '0; ujtag.urstb = 1'b1; ujtag.udrck = 1'b1;
    ujtag.udrcap = 1'b0; ujtag.udrsh = 1'b0; ujtag.udrupd = 1'b0; ujtag.utdi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_utdo", ujtag.utdo, 1'b0);
    check("reset_ctrl_reg", ctrl_reg, 8'h00);
    check("reset_ctrl_update", ctrl_update, 1'b0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (4) @(negedge clk);

    // Probe scan with 8 extra shifts: overscan returns utdi delayed by 32
    probe = 32'hDEADBEEF;
    scan(IR_P, 40, 64'h5A, rd);
    check("probe_first8_lsb_first", rd[7:0], 8'hEF);
    check("probe_word", rd[31:0], 32'hDEADBEEF);
    check("probe_overscan", rd[39:32], 8'h5A);
    do_update(cnt, first);
    check("probe_update_ignored_pulses", cnt, 0);
    check("probe_update_ignored_ctrl", ctrl_reg, 8'h00);

    // Control write then read back
    scan(IR_C, 32, 64'h3C, rd);
    do_update(cnt, first);
    check("ctrl_write_value", ctrl_reg, 8'h3C);
    check("ctrl_update_pulses", cnt, 1);
    check("ctrl_update_latency", first, 3);
    scan(IR_C, 8, 64'h0, rd);
    check("ctrl_readback", rd[7:0], 8'h3C);

    // Unselected IR: utdo stays low, update has no effect
    scan(8'h10, 16, 64'hFFFF, rd);
    check("unsel_utdo", rd[15:0], 16'h0000);
    do_update(cnt, first);
    check("unsel_update_pulses", cnt, 0);
    check("unsel_ctrl_kept", ctrl_reg, 8'h3C);

    // TAP reset for 4 TCKs in the middle of a control shift
    scan(IR_C, 3, 64'h7, rd);
    @(negedge clk);
    ujtag.urstb = 1'b0;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      tck(1'b0, 1'b1, 1'b1, b);
      acc[i] = b;
    end
    check("urstb_utdo_during", acc, 4'h0);
    @(negedge clk);
    ujtag.urstb = 1'b1;
    repeat (4) @(negedge clk);
    check("urstb_ctrl_cleared", ctrl_reg, 8'h00);
    check("urstb_utdo_cleared", ujtag.utdo, 1'b0);
    probe = 32'h600DF00D;
    scan(IR_P, 32, 64'h0, rd);
    check("urstb_next_probe", rd[31:0], 32'h600DF00D);

    // reset_n pulsed mid-shift
    scan(IR_C, 32, 64'hA5, rd);
    do_update(cnt, first);
    check("ctrl_write_a5", ctrl_reg, 8'hA5);
    probe = 32'h0F0F1234;
    scan(IR_P, 5, 64'h0, rd);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rstn_utdo_now", ujtag.utdo, 1'b0);
    check("rstn_ctrl_now", ctrl_reg, 8'h00);
    check("rstn_update_now", ctrl_update, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      tck(1'b0, 1'b1, 1'b1, b);
      acc[i] = b;
    end
    check("rstn_shift_before_capture", acc, 4'h0);
    scan(IR_P, 32, 64'h0, rd);
    check("rstn_next_probe", rd[31:0], 32'h0F0F1234);

`ifdef JTAG_DBG_TRIGGER_EN
    scan(IR_C, 32, 64'h01, rd);
    do_update(cnt, first);
    check("trig_arm_pulses", cnt, 1);
    probe = 32'h12345678;
    @(negedge clk);
    trig = 1'b1;
    repeat (6) @(negedge clk);
    probe = 32'h0;
    trig  = 1'b0;
    repeat (4) @(negedge clk);
    scan(IR_P, 32, 64'h0, rd);
    check("trig_snapshot", rd[31:0], 32'h12345678);
    scan(IR_C, 8, 64'h0, rd);
    check("trig_ctrl_readback", rd[7:0], 8'h81);
`endif

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
